// File: rtl/adc_int_to_float_feeder.sv
// Converts signed ADC samples to IEEE-754 single precision, one sample in flight.
// The normaliser shifts one bit per cycle; the result is held until the consumer takes it.
module adc_int_to_float_feeder #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned SCALE_SHIFT = 0
) (
  input  logic              i_CLK,
  input  logic              i_RSTN,
  input  logic [DATA_W-1:0] i_ADC_DATA,
  input  logic              i_ADC_DATA_VALID,
  output logic              o_ADC_DATA_READY,
  output logic [31:0]       o_X_DATA,
  output logic              o_X_DATA_VALID,
  input  logic              i_X_DATA_READY,
  output logic              o_OVERRUN,
  input  logic              i_OVR_CLR
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [7:0] ExpBase = 8'(127 + DATA_W - 1 - SCALE_SHIFT);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StNorm = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [31:0]       xdata_q, xdata_d;
  logic              ovr_q, ovr_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0] abs_w;
  logic [22:0]       mant_w;
  logic [7:0]        exp_w;

  // Two's-complement negate also maps the most negative code onto 2^(DATA_W-1).
  assign abs_w  = i_ADC_DATA[DATA_W-1] ? (~i_ADC_DATA + DATA_W'(1)) : i_ADC_DATA;
  assign mant_w = 23'(mag_q[DATA_W-2:0]) << (24 - DATA_W);
  assign exp_w  = ExpBase - 8'(cnt_q);

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    valid_d = valid_q;
    xdata_d = xdata_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (i_ADC_DATA_VALID && ready_q) begin
          sign_d  = i_ADC_DATA[DATA_W-1];
          mag_d   = abs_w;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = StNorm;
        end else begin
          ready_d = 1'b1;
        end
      end
      StNorm: begin
        if (mag_q == '0) begin
          xdata_d = 32'h0000_0000;
          valid_d = 1'b1;
          state_d = StOut;
        end else if (mag_q[DATA_W-1]) begin
          xdata_d = {sign_q, exp_w, mant_w};
          valid_d = 1'b1;
          state_d = StOut;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StOut: begin
        if (i_X_DATA_READY) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // A sample offered while busy wins over a simultaneous clear.
  always_comb begin
    ovr_d = ovr_q;
    if (i_ADC_DATA_VALID && !ready_q) begin
      ovr_d = 1'b1;
    end else if (i_OVR_CLR) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      xdata_q <= 32'h0;
      ovr_q   <= 1'b0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      xdata_q <= xdata_d;
      ovr_q   <= ovr_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ADC_DATA_READY = ready_q;
  assign o_X_DATA         = xdata_q;
  assign o_X_DATA_VALID   = valid_q;
  assign o_OVERRUN        = ovr_q;

endmodule
